// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, error codes reported by the mod
// sequencer, and the sequencer state encoding.
package alu_pkg;

  // 3-bit ALU op encodings on alu_ctr.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MOD = 3'b111;

  // Completion status reported alongside the remainder.
  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_DIV0    = 2'b01,
    ERR_NEG     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  // Mod sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMP  = 2'b01,
    ST_SUB  = 2'b10,
    ST_DONE = 2'b11
  } seq_state_e;

endpackage

// File: rtl/alu_mod_sequencer.sv
// Multi-cycle remainder (dividend mod divisor) by repeated compare/subtract
// on the shared ALU. The sequencer requests the ALU with alu_req and only
// advances in cycles where alu_gnt is high; the CPU-side operand mux routes
// alu_src1/alu_src2/alu_ctr into the ALU when granted.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  request pulse, honoured in IDLE only
//   dividend, divisor      operands, captured on start acceptance
//   busy                   high from the cycle after acceptance through DONE
//   done                   one-cycle completion pulse
//   result, err_code       remainder and status, held until next completion
//   alu_req, alu_gnt       ALU ownership handshake
//   alu_src1, alu_src2     ALU operands (current remainder, latched divisor)
//   alu_ctr                ALU op (SLT in CMP, SUB in SUB, AND otherwise)
//   alu_result             combinational ALU result for this cycle
module alu_mod_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       err_code,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_result
);

  seq_state_e        state_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  div_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] iter_d;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  result_q;
  err_e              err_q;
  logic              timeout;

  assign iter_d  = iter_q + 1'b1;
  // MAX_ITER fits in ITER_W bits, so iter_d reaches it before it could wrap.
  assign timeout = (iter_d == ITER_W'(MAX_ITER));

  // ALU-facing signals decode from state and registers only, so there is no
  // combinational path from any input to these outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    alu_req  = 1'b0;
    alu_src1 = '0;
    alu_src2 = '0;
    alu_ctr  = ALU_AND;
    unique case (state_q)
      ST_CMP: begin
        alu_req  = 1'b1;
        alu_src1 = rem_q;
        alu_src2 = div_q;
        alu_ctr  = ALU_SLT;
      end
      ST_SUB: begin
        alu_req  = 1'b1;
        alu_src1 = rem_q;
        alu_src2 = div_q;
        alu_ctr  = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values, independent of statement order.
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= ERR_OK;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            rem_q  <= dividend;
            div_q  <= divisor;
            iter_q <= '0;
            busy_q <= 1'b1;
            // Divide-by-zero is reported ahead of a negative operand.
            if (divisor == '0) begin
              state_q  <= ST_DONE;
              result_q <= '0;
              err_q    <= ERR_DIV0;
              done_q   <= 1'b1;
            end else if (dividend[WIDTH-1] || divisor[WIDTH-1]) begin
              state_q  <= ST_DONE;
              result_q <= '0;
              err_q    <= ERR_NEG;
              done_q   <= 1'b1;
            end else begin
              state_q <= ST_CMP;
            end
          end
        end
        ST_CMP: begin
          if (alu_gnt) begin
            // SLT result bit 0 set means rem < div: remainder is final.
            if (alu_result[0]) begin
              state_q  <= ST_DONE;
              result_q <= rem_q;
              err_q    <= ERR_OK;
              done_q   <= 1'b1;
            end else begin
              state_q <= ST_SUB;
            end
          end
        end
        ST_SUB: begin
          if (alu_gnt) begin
            rem_q  <= alu_result;
            iter_q <= iter_d;
            if (timeout) begin
              state_q  <= ST_DONE;
              result_q <= alu_result;
              err_q    <= ERR_TIMEOUT;
              done_q   <= 1'b1;
            end else begin
              state_q <= ST_CMP;
            end
          end
        end
        ST_DONE: begin
          // start is deliberately not sampled here.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_alu_mod_sequencer.sv
// Directed bench for alu_mod_sequencer: a vector table of operand pairs with
// hand-computed remainders, status and completion latency, plus sequences
// for ALU stalls, the op sequence, mid-operation reset, ignored starts and a
// short-timeout instance.
module tb_alu_mod_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters).
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, alu_req, alu_gnt;
  logic [31:0] result, alu_src1, alu_src2, alu_result;
  logic [1:0]  err_code;
  logic [2:0]  alu_ctr;

  // Short-timeout instance with the ALU always granted.
  logic        t_start = 1'b0;
  logic [31:0] t_dividend = '0;
  logic [31:0] t_divisor = '0;
  logic        t_busy, t_done, t_alu_req;
  logic [31:0] t_result, t_alu_src1, t_alu_src2, t_alu_result;
  logic [1:0]  t_err_code;
  logic [2:0]  t_alu_ctr;

  int n_checks = 0;
  int n_errors = 0;

  // Grant generator: when stall_en is set, each ALU state waits 3 cycles.
  bit       stall_en = 1'b0;
  int       stall_cnt = 0;
  assign alu_gnt = !stall_en || (stall_cnt == 3);
  always @(posedge clk) begin
    if (!alu_req || alu_gnt) stall_cnt <= 0;
    else                     stall_cnt <= stall_cnt + 1;
  end

  // Reference shared ALU: SLT and SUB are the only ops the sequencer uses.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b100:  return {31'd0, (a < b)};
      3'b110:  return a - b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result   = alu_fn(alu_src1, alu_src2, alu_ctr);
  assign t_alu_result = alu_fn(t_alu_src1, t_alu_src2, t_alu_ctr);

  alu_mod_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .err_code   (err_code),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ctr    (alu_ctr),
    .alu_result (alu_result)
  );

  alu_mod_sequencer #(.MAX_ITER(4)) dut_t (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (t_start),
    .dividend   (t_dividend),
    .divisor    (t_divisor),
    .busy       (t_busy),
    .done       (t_done),
    .result     (t_result),
    .err_code   (t_err_code),
    .alu_req    (t_alu_req),
    .alu_gnt    (1'b1),
    .alu_src1   (t_alu_src1),
    .alu_src2   (t_alu_src2),
    .alu_ctr    (t_alu_ctr),
    .alu_result (t_alu_result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ALU ops issued in granted cycles during the last run_op.
  logic [2:0] ctr_hist[$];

  // Issues one operation starting at the next falling edge and follows it to
  // completion. edges counts rising edges from the accepting edge (=1) to the
  // one after which done is seen. Optional poke pulses a start with other
  // operands mid-operation and again in the DONE cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit stall, input bit poke,
                        output int edges, output logic [31:0] res,
                        output logic [1:0] err, output bit any_req,
                        output bit stable_ok, output bit busy_ok);
    logic       p_req, p_gnt;
    logic [31:0] p_src1, p_src2;
    logic [2:0] p_ctr;
    @(negedge clk);
    stall_en = stall;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    ctr_hist.delete();
    @(posedge clk); #1;
    start     = 1'b0;
    edges     = 1;
    busy_ok   = (busy === 1'b1);
    any_req   = 1'b0;
    stable_ok = 1'b1;
    while (done !== 1'b1 && edges < 2000) begin
      if (alu_req === 1'b1) any_req = 1'b1;
      if (alu_req === 1'b1 && alu_gnt === 1'b1) ctr_hist.push_back(alu_ctr);
      p_req = alu_req; p_gnt = alu_gnt;
      p_src1 = alu_src1; p_src2 = alu_src2; p_ctr = alu_ctr;
      if (poke && edges == 3) begin
        start = 1'b1; dividend = 32'd4; divisor = 32'd9;
      end
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      if (p_req && !p_gnt &&
          (alu_ctr !== p_ctr || alu_src1 !== p_src1 || alu_src2 !== p_src2 || alu_req !== 1'b1))
        stable_ok = 1'b0;
    end
    res = result;
    err = err_code;
    busy_ok = busy_ok && (busy === 1'b1);
    if (poke) begin
      start = 1'b1; dividend = 32'd4; divisor = 32'd9;
    end
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = busy_ok && (busy === 1'b0) && (done === 1'b0);
    stall_en = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [1:0]  exp_err;
    int          exp_edges;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          edges;
    logic [31:0] res;
    logic [1:0]  err;
    bit          any_req, stable_ok, busy_ok, done_seen;
    logic [2:0]  exp_seq[7];

    // a, b, remainder, status, edges to done (2q+2 ok, 1 on error)
    vecs[0] = '{32'd17,         32'd5,         32'd2, 2'b00, 8};
    vecs[1] = '{32'd4,          32'd9,         32'd4, 2'b00, 2};
    vecs[2] = '{32'd7,          32'd0,         32'd0, 2'b01, 1};
    vecs[3] = '{32'h8000_0001,  32'd3,         32'd0, 2'b10, 1};
    vecs[4] = '{32'h8000_0000,  32'd0,         32'd0, 2'b01, 1};
    vecs[5] = '{32'd3,          32'h8000_0000, 32'd0, 2'b10, 1};
    vecs[6] = '{32'd10,         32'd5,         32'd0, 2'b00, 6};
    vecs[7] = '{32'd5,          32'd5,         32'd0, 2'b00, 4};
    vecs[8] = '{32'd0,          32'd7,         32'd0, 2'b00, 2};
    vecs[9] = '{32'd100,        32'd7,         32'd2, 2'b00, 30};

    exp_seq = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b100, 3'b110, 3'b100};

    // Reset state.
    #12;
    check("reset busy",     {31'd0, busy},    32'd0);
    check("reset done",     {31'd0, done},    32'd0);
    check("reset result",   result,           32'd0);
    check("reset err",      {30'd0, err_code}, 32'd0);
    check("reset alu_req",  {31'd0, alu_req}, 32'd0);
    check("reset src1",     alu_src1,         32'd0);
    check("reset src2",     alu_src2,         32'd0);
    check("reset ctr",      {29'd0, alu_ctr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, 1'b0, edges, res, err, any_req, stable_ok, busy_ok);
      check($sformatf("vec%0d edges", i),  edges, vecs[i].exp_edges);
      check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d err", i),    {30'd0, err}, {30'd0, vecs[i].exp_err});
      check($sformatf("vec%0d alu_req used", i), {31'd0, any_req},
            {31'd0, (vecs[i].exp_err == 2'b00)});
      check($sformatf("vec%0d busy/done shape", i), {31'd0, busy_ok}, 32'd1);
    end

    // Op sequence for 17 mod 5 with a start poked mid-run and in DONE.
    run_op(32'd17, 32'd5, 1'b0, 1'b1, edges, res, err, any_req, stable_ok, busy_ok);
    check("poke edges",  edges, 32'd8);
    check("poke result", res, 32'd2);
    check("poke err",    {30'd0, err}, 32'd0);
    check("poke busy/done shape", {31'd0, busy_ok}, 32'd1);
    check("op count", ctr_hist.size(), 32'd7);
    for (int k = 0; k < 7; k++)
      if (k < ctr_hist.size())
        check($sformatf("op seq %0d", k), {29'd0, ctr_hist[k]}, {29'd0, exp_seq[k]});
    check("no stray done after poke", {31'd0, done}, 32'd0);

    // Same operation with a 3-cycle grant delay on every ALU state.
    run_op(32'd17, 32'd5, 1'b1, 1'b0, edges, res, err, any_req, stable_ok, busy_ok);
    check("stall edges",  edges, 32'd29);
    check("stall result", res, 32'd2);
    check("stall err",    {30'd0, err}, 32'd0);
    check("stall operands stable", {31'd0, stable_ok}, 32'd1);
    check("stall op count", ctr_hist.size(), 32'd7);

    // Reset while in SUB of 17 mod 5.
    @(negedge clk);
    dividend = 32'd17; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre-reset in SUB", {29'd0, alu_ctr}, 32'd6);
    rst_n = 1'b0;
    #1;
    check("midrst busy",    {31'd0, busy},     32'd0);
    check("midrst done",    {31'd0, done},     32'd0);
    check("midrst result",  result,            32'd0);
    check("midrst err",     {30'd0, err_code}, 32'd0);
    check("midrst alu_req", {31'd0, alu_req},  32'd0);
    check("midrst src1",    alu_src1,          32'd0);
    check("midrst src2",    alu_src2,          32'd0);
    check("midrst ctr",     {29'd0, alu_ctr},  32'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    check("no done across reset", {31'd0, done_seen}, 32'd0);
    run_op(32'd4, 32'd9, 1'b0, 1'b0, edges, res, err, any_req, stable_ok, busy_ok);
    check("post-reset edges",  edges, 32'd2);
    check("post-reset result", res, 32'd4);

    // Timeout instance: 100 mod 3 stops after 4 subtractions.
    @(negedge clk);
    t_dividend = 32'd100; t_divisor = 32'd3; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    edges = 1;
    while (t_done !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check("timeout edges",  edges, 32'd9);
    check("timeout result", t_result, 32'd88);
    check("timeout err",    {30'd0, t_err_code}, 32'd3);
    check("timeout busy",   {31'd0, t_busy}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
